// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the combinational ALU.
//   Holds issued ALU/branch instructions until both operands are known. It
//   watches the ALU and LSB broadcast buses to fill in missing operands, and
//   each cycle it sends the lowest-index ready entry to registered ALU outputs.
// Ports:
//   clk, rst (sync, active high), rdy (global freeze), clear (ROB flush)
//   issue_*   : dispatcher write port; RS_full back-pressures it
//   CDB_ALU_* : ALU result broadcast
//   CDB_LSB_* : load result broadcast
//   ALU_S, Op, Vj, Vk, Reorder, A, pc : registered ALU input bundle
`ifndef OpBus
`define OpBus 5:0
`endif
`ifndef DataBus
`define DataBus 31:0
`endif
`ifndef ROBBus
`define ROBBus 3:0
`endif
`ifndef AddrBus
`define AddrBus 31:0
`endif

package alu_rs_pkg;
  typedef struct packed {
    logic [`OpBus]   op;
    logic [`DataBus] vj;
    logic [`DataBus] vk;
    logic            qj_s;
    logic            qk_s;
    logic [`ROBBus]  qj;
    logic [`ROBBus]  qk;
    logic [`ROBBus]  reorder;
    logic [`DataBus] a;
    logic [`AddrBus] pc;
  } rs_ent_t;
endpackage

// One station slot. This slot handles both the fill-time forwarding and the
// wakeup. Both use the same bus-matching path. On a fill, the path is applied
// to the incoming instruction. Otherwise it is applied to the stored copy.
module alu_rs_entry
  import alu_rs_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            clear,
  input  logic            wr,
  input  logic            sel,
  input  rs_ent_t         din,
  input  logic            alu_s,
  input  logic [`ROBBus]  alu_tag,
  input  logic [`DataBus] alu_val,
  input  logic            lsb_s,
  input  logic [`ROBBus]  lsb_tag,
  input  logic [`DataBus] lsb_val,
  output logic            busy,
  output rs_ent_t         ent
);
  rs_ent_t src, nxt;

  // If both buses carry the same tag, the ALU bus takes priority.
  always_comb begin
    src = wr ? din : ent;
    nxt = src;
    if (src.qj_s) begin
      if (alu_s && alu_tag == src.qj) begin
        nxt.vj = alu_val; nxt.qj_s = 1'b0;
      end else if (lsb_s && lsb_tag == src.qj) begin
        nxt.vj = lsb_val; nxt.qj_s = 1'b0;
      end
    end
    if (src.qk_s) begin
      if (alu_s && alu_tag == src.qk) begin
        nxt.vk = alu_val; nxt.qk_s = 1'b0;
      end else if (lsb_s && lsb_tag == src.qk) begin
        nxt.vk = lsb_val; nxt.qk_s = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      ent  <= '0;
    end else if (clear) begin
      busy <= 1'b0;
    end else if (rdy) begin
      if (wr) begin
        busy <= 1'b1;
        ent  <= nxt;
      end else if (busy) begin
        if (sel) busy <= 1'b0;
        else     ent  <= nxt;
      end
    end
  end
endmodule

module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE  = 16,
  parameter int RS_IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            clear,
  input  logic            issue_S,
  input  logic [`OpBus]   issue_Op,
  input  logic [`DataBus] issue_Vj,
  input  logic [`DataBus] issue_Vk,
  input  logic            issue_Qj_S,
  input  logic            issue_Qk_S,
  input  logic [`ROBBus]  issue_Qj,
  input  logic [`ROBBus]  issue_Qk,
  input  logic [`ROBBus]  issue_Reorder,
  input  logic [`DataBus] issue_A,
  input  logic [`AddrBus] issue_pc,
  output logic            RS_full,
  input  logic            CDB_ALU_S,
  input  logic [`ROBBus]  CDB_ALU_Reorder,
  input  logic [`DataBus] CDB_ALU_Value,
  input  logic            CDB_LSB_S,
  input  logic [`ROBBus]  CDB_LSB_Reorder,
  input  logic [`DataBus] CDB_LSB_Value,
  output logic            ALU_S,
  output logic [`OpBus]   Op,
  output logic [`DataBus] Vj,
  output logic [`DataBus] Vk,
  output logic [`ROBBus]  Reorder,
  output logic [`DataBus] A,
  output logic [`AddrBus] pc
);
  logic    [RS_SIZE-1:0] busy, ready, wr, sel;
  rs_ent_t [RS_SIZE-1:0] ents;
  rs_ent_t               din;
  logic [RS_IDX_W-1:0]   free_idx, sel_idx;
  logic                  any_ready, do_issue;

  assign din = '{op: issue_Op, vj: issue_Vj, vk: issue_Vk,
                 qj_s: issue_Qj_S, qk_s: issue_Qk_S, qj: issue_Qj, qk: issue_Qk,
                 reorder: issue_Reorder, a: issue_A, pc: issue_pc};

  // Full is computed from the busy bits at the start of the cycle. So a slot
  // freed by this cycle's dispatch can only be reused starting next cycle.
  assign RS_full  = &busy;
  assign do_issue = issue_S && !RS_full;

  // Lowest-index free slot and lowest-index ready slot.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    any_ready = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) free_idx = RS_IDX_W'(i);
      if (ready[i]) begin
        sel_idx   = RS_IDX_W'(i);
        any_ready = 1'b1;
      end
    end
  end

  for (genvar e = 0; e < RS_SIZE; e++) begin : g_ent
    assign ready[e] = busy[e] && !ents[e].qj_s && !ents[e].qk_s;
    assign wr[e]    = do_issue && (free_idx == RS_IDX_W'(e));
    assign sel[e]   = any_ready && (sel_idx == RS_IDX_W'(e));
    alu_rs_entry u_ent (
      .clk     (clk),
      .rst     (rst),
      .rdy     (rdy),
      .clear   (clear),
      .wr      (wr[e]),
      .sel     (sel[e]),
      .din     (din),
      .alu_s   (CDB_ALU_S),
      .alu_tag (CDB_ALU_Reorder),
      .alu_val (CDB_ALU_Value),
      .lsb_s   (CDB_LSB_S),
      .lsb_tag (CDB_LSB_Reorder),
      .lsb_val (CDB_LSB_Value),
      .busy    (busy[e]),
      .ent     (ents[e])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_S   <= 1'b0;
      Op      <= '0;
      Vj      <= '0;
      Vk      <= '0;
      Reorder <= '0;
      A       <= '0;
      pc      <= '0;
    end else if (clear || !rdy) begin
      ALU_S <= 1'b0;
    end else if (any_ready) begin
      ALU_S   <= 1'b1;
      Op      <= ents[sel_idx].op;
      Vj      <= ents[sel_idx].vj;
      Vk      <= ents[sel_idx].vk;
      Reorder <= ents[sel_idx].reorder;
      A       <= ents[sel_idx].a;
      pc      <= ents[sel_idx].pc;
    end else begin
      ALU_S <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
`ifndef OpBus
`define OpBus 5:0
`endif
`ifndef DataBus
`define DataBus 31:0
`endif
`ifndef ROBBus
`define ROBBus 3:0
`endif
`ifndef AddrBus
`define AddrBus 31:0
`endif

module tb_alu_rs;
  logic clk = 1'b0;
  logic rst, rdy, clear, issue_S, issue_Qj_S, issue_Qk_S;
  logic [`OpBus]   issue_Op;
  logic [`DataBus] issue_Vj, issue_Vk, issue_A;
  logic [`ROBBus]  issue_Qj, issue_Qk, issue_Reorder;
  logic [`AddrBus] issue_pc;
  logic RS_full;
  logic CDB_ALU_S, CDB_LSB_S;
  logic [`ROBBus]  CDB_ALU_Reorder, CDB_LSB_Reorder;
  logic [`DataBus] CDB_ALU_Value, CDB_LSB_Value;
  logic ALU_S;
  logic [`OpBus]   Op;
  logic [`DataBus] Vj, Vk, A;
  logic [`ROBBus]  Reorder;
  logic [`AddrBus] pc;

  localparam logic [`OpBus] ADD = 6'd1, ADDI = 6'd2;

  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_S(issue_S), .issue_Op(issue_Op), .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .issue_Qj_S(issue_Qj_S), .issue_Qk_S(issue_Qk_S), .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .issue_Reorder(issue_Reorder), .issue_A(issue_A), .issue_pc(issue_pc),
    .RS_full(RS_full),
    .CDB_ALU_S(CDB_ALU_S), .CDB_ALU_Reorder(CDB_ALU_Reorder), .CDB_ALU_Value(CDB_ALU_Value),
    .CDB_LSB_S(CDB_LSB_S), .CDB_LSB_Reorder(CDB_LSB_Reorder), .CDB_LSB_Value(CDB_LSB_Value),
    .ALU_S(ALU_S), .Op(Op), .Vj(Vj), .Vk(Vk), .Reorder(Reorder), .A(A), .pc(pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic [`OpBus] op, input logic [31:0] vj, input logic [31:0] vk,
                     input logic qjs, input logic [3:0] qj, input logic qks, input logic [3:0] qk,
                     input logic [3:0] rob, input logic [31:0] a);
    issue_S = 1'b1; issue_Op = op; issue_Vj = vj; issue_Vk = vk;
    issue_Qj_S = qjs; issue_Qj = qj; issue_Qk_S = qks; issue_Qk = qk;
    issue_Reorder = rob; issue_A = a; issue_pc = 32'h1000 + {28'd0, rob};
  endtask

  task automatic cdb_idle();
    CDB_ALU_S = 1'b0; CDB_LSB_S = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    cdb_idle();
    CDB_ALU_Reorder = '0; CDB_ALU_Value = '0; CDB_LSB_Reorder = '0; CDB_LSB_Value = '0;
    // issue pulse during reset must leave nothing behind
    iss(ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 32'd0);
    tick(); tick();
    chk("rst_alu_s", {31'd0, ALU_S}, 32'd0);
    chk("rst_reorder", {28'd0, Reorder}, 32'd0);
    chk("rst_full", {31'd0, RS_full}, 32'd0);
    rst = 1'b0; issue_S = 1'b0;
    tick(); tick();
    chk("rst_no_entry", {31'd0, ALU_S}, 32'd0);

    // ready ADD
    iss(ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 32'd0);
    tick(); issue_S = 1'b0;
    chk("add_fill_s", {31'd0, ALU_S}, 32'd0);
    tick();
    chk("add_s", {31'd0, ALU_S}, 32'd1);
    chk("add_op", {26'd0, Op}, 32'd1);
    chk("add_vj", Vj, 32'd5);
    chk("add_vk", Vk, 32'd7);
    chk("add_rob", {28'd0, Reorder}, 32'd3);
    chk("add_pc", pc, 32'h1003);
    tick();
    chk("add_done", {31'd0, ALU_S}, 32'd0);

    // forwarding at issue from LSB bus
    iss(ADDI, 32'd0, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, 4'd4, 32'h10);
    CDB_LSB_S = 1'b1; CDB_LSB_Reorder = 4'd6; CDB_LSB_Value = 32'h100;
    tick(); issue_S = 1'b0; cdb_idle();
    tick();
    chk("fwd_s", {31'd0, ALU_S}, 32'd1);
    chk("fwd_vj", Vj, 32'h100);
    chk("fwd_a", A, 32'h10);
    chk("fwd_op", {26'd0, Op}, 32'd2);

    // delayed wakeup, broadcast two cycles after issue
    iss(ADDI, 32'd0, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, 4'd5, 32'h20);
    tick(); issue_S = 1'b0;
    tick();
    chk("wake_wait", {31'd0, ALU_S}, 32'd0);
    CDB_LSB_S = 1'b1; CDB_LSB_Reorder = 4'd6; CDB_LSB_Value = 32'h200;
    tick(); cdb_idle();
    chk("wake_bcast_cyc", {31'd0, ALU_S}, 32'd0);
    tick();
    chk("wake_s", {31'd0, ALU_S}, 32'd1);
    chk("wake_vj", Vj, 32'h200);
    chk("wake_rob", {28'd0, Reorder}, 32'd5);

    // both buses match one tag: ALU value wins
    iss(ADD, 32'd0, 32'd0, 1'b1, 4'd4, 1'b0, 4'd0, 4'd2, 32'd0);
    tick(); issue_S = 1'b0;
    CDB_ALU_S = 1'b1; CDB_ALU_Reorder = 4'd4; CDB_ALU_Value = 32'hA;
    CDB_LSB_S = 1'b1; CDB_LSB_Reorder = 4'd4; CDB_LSB_Value = 32'hB;
    tick(); cdb_idle();
    tick();
    chk("prio_s", {31'd0, ALU_S}, 32'd1);
    chk("prio_vj", Vj, 32'hA);

    // fill all 16 slots waiting on tag 9 through Qk
    for (int i = 0; i < 16; i++) begin
      iss(ADD, 32'(i), 32'd0, 1'b0, 4'd0, 1'b1, 4'd9, 4'(i), 32'd0);
      tick();
    end
    chk("full_set", {31'd0, RS_full}, 32'd1);
    // 17th issue (ready) must be ignored
    iss(ADD, 32'd99, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd15, 32'd0);
    tick(); issue_S = 1'b0;
    chk("full_hold", {31'd0, RS_full}, 32'd1);
    chk("full_no_disp", {31'd0, ALU_S}, 32'd0);
    CDB_ALU_S = 1'b1; CDB_ALU_Reorder = 4'd9; CDB_ALU_Value = 32'h900;
    tick(); cdb_idle();
    chk("full_wake_cyc", {31'd0, ALU_S}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("ord_s_%0d", i), {31'd0, ALU_S}, 32'd1);
      chk($sformatf("ord_rob_%0d", i), {28'd0, Reorder}, 32'(i));
      chk($sformatf("ord_vj_%0d", i), Vj, 32'(i));
      chk($sformatf("ord_vk_%0d", i), Vk, 32'h900);
      if (i == 0) chk("full_drop", {31'd0, RS_full}, 32'd0);
    end
    tick();
    chk("ord_drained", {31'd0, ALU_S}, 32'd0);

    // flush of 4 waiting entries
    for (int i = 0; i < 4; i++) begin
      iss(ADD, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'(i + 8), 32'd0);
      tick();
    end
    issue_S = 1'b0; clear = 1'b1;
    tick(); clear = 1'b0;
    chk("flush_s", {31'd0, ALU_S}, 32'd0);
    chk("flush_full", {31'd0, RS_full}, 32'd0);
    CDB_ALU_S = 1'b1; CDB_ALU_Reorder = 4'd2; CDB_ALU_Value = 32'h55;
    tick(); cdb_idle();
    tick();
    chk("flush_dead1", {31'd0, ALU_S}, 32'd0);
    tick();
    chk("flush_dead2", {31'd0, ALU_S}, 32'd0);

    // rdy stall
    iss(ADD, 32'h33, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7, 32'd0);
    tick(); issue_S = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_s_%0d", i), {31'd0, ALU_S}, 32'd0);
    end
    chk("stall_hold_rob", {28'd0, Reorder}, 32'd15);
    rdy = 1'b1;
    tick();
    chk("stall_go_s", {31'd0, ALU_S}, 32'd1);
    chk("stall_go_rob", {28'd0, Reorder}, 32'd7);
    chk("stall_go_vj", Vj, 32'h33);
    tick();
    chk("stall_done", {31'd0, ALU_S}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
